// File: rtl/tri_bus_pkg.sv
// ============================================================================
// tri_bus_pkg : shared types and helpers for the tri-state bus arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package tri_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_e;

    localparam int TA_W = 2;

    // Saturates at max instead of wrapping; callers narrow the result.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max);
        return (val >= max) ? val : val + 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, first requester after ptr_i
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import tri_bus_pkg::*;
#(
    parameter int NCH = 2,
    parameter int PW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req_i,
    input  logic [PW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic           valid_o
);

    logic [PW-1:0] w_idx;

    // Scan starts one past the pointer so the last owner has lowest priority.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= NCH; i++) begin
            w_idx = PW'((int'(ptr_i) + i) % NCH);
            if (!valid_o && req_i[w_idx]) begin
                gnt_o[w_idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tri_bus_arbiter.sv
// ============================================================================
// tri_bus_arbiter : round-robin owner of a shared tri-state bus with
//                   turnaround gaps and external-driver contention detection
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int W          = 1,
    parameter int TURNAROUND = 1,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     req_i,
    input  logic [NCH*W-1:0]   to_pad_i,
    input  logic [NCH-1:0]     ie_i,
    input  logic [W-1:0]       ext_in_i,
    input  logic               ext_en_i,
    input  logic               clr_err_i,
    output logic [NCH-1:0]     gnt_o,
    output logic [W-1:0]       bus_out_o,
    output logic               bus_en_o,
    output logic [NCH*W-1:0]   from_pad_o,
    output logic               contention_o,
    output logic [CNT_W-1:0]   cnt_o
);

    localparam int          c_pw      = $clog2(NCH);
    localparam logic [63:0] c_cnt_max = 64'((65'd1 << CNT_W) - 65'd1);

    state_e             state_q, state_d;
    logic [NCH-1:0]     gnt_q, gnt_d;
    logic [c_pw-1:0]    ptr_q, ptr_d;
    logic [TA_W-1:0]    ta_q, ta_d;
    logic [NCH*W-1:0]   from_pad_q, from_pad_d;
    logic               contention_q, contention_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NCH-1:0]     w_arb_gnt;
    logic               w_arb_valid;
    logic [c_pw-1:0]    w_arb_idx;
    logic               w_arb_en;
    logic               w_owner_req;
    logic [W-1:0]       w_bus_out;
    logic [W-1:0]       w_bus_val;

    rr_arbiter #(
        .NCH (NCH),
        .PW  (c_pw)
    ) u_rr (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (w_arb_gnt),
        .valid_o (w_arb_valid)
    );

    always_comb begin
        w_arb_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_arb_gnt[k]) w_arb_idx = c_pw'(k);
        end
    end

    assign w_owner_req = |(req_i & gnt_q);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        ta_d     = ta_q;
        w_arb_en = 1'b0;
        case (state_q)
            IDLE: w_arb_en = 1'b1;
            OWN: begin
                if (!w_owner_req) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                    // With no turnaround the next owner is chosen in the drop cycle.
                    if (TURNAROUND == 0) begin
                        w_arb_en = 1'b1;
                    end else begin
                        state_d = TURN;
                        ta_d    = TA_W'(TURNAROUND - 1);
                    end
                end
            end
            TURN: begin
                if (ta_q == '0) w_arb_en = 1'b1;
                else            ta_d = ta_q - TA_W'(1);
            end
            default: state_d = IDLE;
        endcase
        if (w_arb_en) begin
            if (w_arb_valid) begin
                state_d = OWN;
                gnt_d   = w_arb_gnt;
                ptr_d   = w_arb_idx;
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        end
    end

    always_comb begin
        w_bus_out = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_q[k]) w_bus_out = w_bus_out | to_pad_i[k*W +: W];
        end
    end

    assign bus_en_o  = |gnt_q;
    assign bus_out_o = w_bus_out;
    assign w_bus_val = (bus_en_o ? w_bus_out : '0) | (ext_en_i ? ext_in_i : '0);

    for (genvar k = 0; k < NCH; k++) begin : g_rx
        assign from_pad_d[k*W +: W] = ie_i[k] ? w_bus_val : '0;
    end

    // A clear in the same cycle as a clash wins over the increment.
    always_comb begin
        contention_d = contention_q;
        cnt_d        = cnt_q;
        if (clr_err_i) begin
            contention_d = 1'b0;
            cnt_d        = '0;
        end else if (bus_en_o && ext_en_i) begin
            contention_d = 1'b1;
            cnt_d        = CNT_W'(sat_inc(64'(cnt_q), c_cnt_max));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            ptr_q        <= c_pw'(NCH - 1);
            ta_q         <= '0;
            from_pad_q   <= '0;
            contention_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            ptr_q        <= ptr_d;
            ta_q         <= ta_d;
            from_pad_q   <= from_pad_d;
            contention_q <= contention_d;
            cnt_q        <= cnt_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign from_pad_o   = from_pad_q;
    assign contention_o = contention_q;
    assign cnt_o        = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_tri_bus_arbiter.sv
// ============================================================================
// tb_tri_bus_arbiter : vector table, directed corner sequences and a random
//                      run against a behavioural bus model
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_tri_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: NCH=2, W=1, one turnaround cycle
    logic       rst_a_n;
    logic [1:0] a_req, a_tp, a_ie, a_gnt, a_from;
    logic       a_ext_in, a_ext_en, a_clr, a_out, a_en, a_cont;
    logic [7:0] a_cnt;

    // Instance B: NCH=4, W=8, one turnaround cycle, 2-bit counter
    logic        rst_b_n;
    logic [3:0]  b_req, b_ie, b_gnt;
    logic [31:0] b_tp, b_from;
    logic [7:0]  b_ext_in, b_out;
    logic        b_ext_en, b_clr, b_en, b_cont;
    logic [1:0]  b_cnt;

    // Instance C: NCH=2, W=1, no turnaround
    logic       rst_c_n;
    logic [1:0] c_req, c_tp, c_ie, c_gnt, c_from;
    logic       c_ext_in, c_ext_en, c_clr, c_out, c_en, c_cont;
    logic [7:0] c_cnt;

    tri_bus_arbiter #(.NCH(2), .W(1), .TURNAROUND(1), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_a_n), .req_i(a_req), .to_pad_i(a_tp), .ie_i(a_ie),
        .ext_in_i(a_ext_in), .ext_en_i(a_ext_en), .clr_err_i(a_clr), .gnt_o(a_gnt),
        .bus_out_o(a_out), .bus_en_o(a_en), .from_pad_o(a_from),
        .contention_o(a_cont), .cnt_o(a_cnt));

    tri_bus_arbiter #(.NCH(4), .W(8), .TURNAROUND(1), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_b_n), .req_i(b_req), .to_pad_i(b_tp), .ie_i(b_ie),
        .ext_in_i(b_ext_in), .ext_en_i(b_ext_en), .clr_err_i(b_clr), .gnt_o(b_gnt),
        .bus_out_o(b_out), .bus_en_o(b_en), .from_pad_o(b_from),
        .contention_o(b_cont), .cnt_o(b_cnt));

    tri_bus_arbiter #(.NCH(2), .W(1), .TURNAROUND(0), .CNT_W(8)) u_c (
        .clk(clk), .rst_n(rst_c_n), .req_i(c_req), .to_pad_i(c_tp), .ie_i(c_ie),
        .ext_in_i(c_ext_in), .ext_en_i(c_ext_en), .clr_err_i(c_clr), .gnt_o(c_gnt),
        .bus_out_o(c_out), .bus_en_o(c_en), .from_pad_o(c_from),
        .contention_o(c_cont), .cnt_o(c_cnt));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset B between edges (call right after tick)
    task automatic reset_b();
        #3 rst_b_n = 1'b0;
        b_req = '0; b_ext_en = 1'b0; b_clr = 1'b0;
        #2 rst_b_n = 1'b1;
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int i = 1; i <= 4; i++) begin
            if (r[(last + i) % 4]) return (last + i) % 4;
        end
        return -1;
    endfunction

    typedef struct {
        logic [1:0] req;
        logic [1:0] tp;
        logic [1:0] gnt;
        logic       en;
        logic       out;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int          m_owner, m_last, m_idle, pick;
        logic        m_cont;
        logic [1:0]  m_cnt;
        logic [31:0] m_from;
        logic [7:0]  bus_val;
        logic [3:0]  exp4, drop;

        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        a_req = '0; a_tp = '0; a_ie = '0; a_ext_in = 1'b0; a_ext_en = 1'b0; a_clr = 1'b0;
        b_req = '0; b_tp = '0; b_ie = '0; b_ext_in = '0; b_ext_en = 1'b0; b_clr = 1'b0;
        c_req = '0; c_tp = '0; c_ie = '0; c_ext_in = 1'b0; c_ext_en = 1'b0; c_clr = 1'b0;

        tbl[0]  = '{2'b11, 2'b01, 2'b01, 1'b1, 1'b1};
        tbl[1]  = '{2'b11, 2'b10, 2'b01, 1'b1, 1'b0};
        tbl[2]  = '{2'b11, 2'b01, 2'b01, 1'b1, 1'b1};
        tbl[3]  = '{2'b10, 2'b11, 2'b00, 1'b0, 1'b0};
        tbl[4]  = '{2'b10, 2'b10, 2'b10, 1'b1, 1'b1};
        tbl[5]  = '{2'b11, 2'b01, 2'b10, 1'b1, 1'b0};
        tbl[6]  = '{2'b01, 2'b11, 2'b00, 1'b0, 1'b0};
        tbl[7]  = '{2'b01, 2'b11, 2'b01, 1'b1, 1'b1};
        tbl[8]  = '{2'b00, 2'b11, 2'b00, 1'b0, 1'b0};
        tbl[9]  = '{2'b00, 2'b11, 2'b00, 1'b0, 1'b0};
        tbl[10] = '{2'b10, 2'b10, 2'b10, 1'b1, 1'b1};
        tbl[11] = '{2'b11, 2'b11, 2'b10, 1'b1, 1'b1};

        #7;
        check("rst_a_gnt", 64'(a_gnt), 64'd0);
        check("rst_a_en", 64'(a_en), 64'd0);
        check("rst_a_from", 64'(a_from), 64'd0);
        check("rst_a_err", 64'({a_cont, a_cnt}), 64'd0);
        check("rst_b_gnt", 64'(b_gnt), 64'd0);
        check("rst_b_err", 64'({b_cont, b_cnt}), 64'd0);
        #5;
        rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            a_req = tbl[i].req;
            a_tp  = tbl[i].tp;
            tick();
            check($sformatf("a_vec%0d_gnt", i), 64'(a_gnt), 64'(tbl[i].gnt));
            check($sformatf("a_vec%0d_en", i), 64'(a_en), 64'(tbl[i].en));
            check($sformatf("a_vec%0d_out", i), 64'(a_out), 64'(tbl[i].out));
        end

        // Asynchronous reset in the middle of an ownership
        #3 rst_a_n = 1'b0;
        #1;
        check("a_async_gnt", 64'(a_gnt), 64'd0);
        check("a_async_en", 64'(a_en), 64'd0);
        #1 rst_a_n = 1'b1;
        a_req = 2'b10;
        tick();
        check("a_after_rst_gnt", 64'(a_gnt), 64'b10);

        // Zero turnaround: back-to-back owners with no bus gap
        c_req = 2'b11; tick();
        check("c_first_gnt", 64'(c_gnt), 64'b01);
        c_req = 2'b10; tick();
        check("c_handoff_gnt", 64'(c_gnt), 64'b10);
        check("c_handoff_en", 64'(c_en), 64'd1);
        c_req = 2'b01; tick();
        check("c_back_gnt", 64'(c_gnt), 64'b01);
        c_req = 2'b00; tick();
        check("c_idle_gnt", 64'(c_gnt), 64'b00);
        c_req = 2'b01; tick();
        check("c_regrant", 64'(c_gnt), 64'b01);

        // Fair rotation, each owner dropping after two cycles
        for (int c = 0; c < 13; c++) begin
            drop  = 4'b0001 << (c / 3);
            b_req = (c % 3 == 2) ? ~drop : 4'b1111;
            tick();
            exp4 = (c % 3 == 2) ? 4'b0000 : 4'(1 << ((c / 3) % 4));
            check($sformatf("b_rot%0d_gnt", c), 64'(b_gnt), 64'(exp4));
            check($sformatf("b_rot%0d_en", c), 64'(b_en), 64'(|exp4));
        end

        // Receive path
        reset_b();
        b_req = 4'b0010; b_tp = 32'h33_22_A5_11; b_ie = 4'b0100;
        tick();
        check("b_rx_gnt", 64'(b_gnt), 64'b0010);
        check("b_rx_out", 64'(b_out), 64'hA5);
        tick();
        check("b_rx_from", 64'(b_from), 64'h00_A5_00_00);

        // Contention with saturation of the 2-bit counter
        b_tp = 32'h33_22_F0_11; b_ext_in = 8'h0F; b_ext_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("b_cnt%0d", i), 64'(b_cnt), 64'((i > 3) ? 3 : i));
            check($sformatf("b_cont%0d", i), 64'(b_cont), 64'd1);
        end
        check("b_resolved_from", 64'(b_from), 64'h00_FF_00_00);
        b_ext_en = 1'b0; b_clr = 1'b1;
        tick();
        check("b_clr", 64'({b_cont, b_cnt}), 64'd0);
        b_ext_en = 1'b1;
        tick();
        check("b_clr_wins", 64'({b_cont, b_cnt}), 64'd0);
        b_clr = 1'b0; b_ext_en = 1'b0;

        // Random traffic against the behavioural model
        tick();
        reset_b();
        m_owner = -1; m_last = 3; m_idle = 0; m_cont = 1'b0; m_cnt = '0; m_from = '0;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) b_req[k] = ~b_req[k];
            end
            b_tp     = $urandom;
            b_ie     = 4'($urandom);
            b_ext_in = 8'($urandom);
            b_ext_en = ($urandom_range(0, 4) == 0);
            b_clr    = ($urandom_range(0, 15) == 0);

            bus_val = (m_owner >= 0 ? b_tp[m_owner*8 +: 8] : 8'h00) | (b_ext_en ? b_ext_in : 8'h00);
            for (int k = 0; k < 4; k++) m_from[k*8 +: 8] = b_ie[k] ? bus_val : 8'h00;
            if (b_clr) begin
                m_cont = 1'b0; m_cnt = '0;
            end else if (m_owner >= 0 && b_ext_en) begin
                m_cont = 1'b1;
                if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
            end

            pick = -2;
            if (m_owner >= 0) begin
                if (!b_req[m_owner]) begin
                    m_owner = -1;
                    m_idle  = 1;
                end
            end else if (m_idle > 1) begin
                m_idle = m_idle - 1;
            end else begin
                m_idle = 0;
                pick   = rr_pick(b_req, m_last);
            end
            if (pick >= 0) begin
                m_owner = pick;
                m_last  = pick;
            end

            tick();
            exp4 = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            check("rnd_gnt", 64'(b_gnt), 64'(exp4));
            check("rnd_bus", 64'({b_en, b_out}),
                  64'({m_owner >= 0, (m_owner >= 0) ? b_tp[m_owner*8 +: 8] : 8'h00}));
            check("rnd_from", 64'(b_from), 64'(m_from));
            check("rnd_err", 64'({b_cont, b_cnt}), 64'({m_cont, m_cnt}));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
- Parametrised successor to the two-pad tri-state checker.
- Arbitrates NCH channels onto one shared W-bit tri-state bus. Uses a registered request/grant handshake, round-robin fairness, enforced turnaround idle cycles and contention detection against an external driver.
- The bus is modelled in the binary-resolved form: separate value and enable signals, with wired-OR resolution. It sits between per-channel pad logic and the bus model used by the tri-state regression.

Parameters:
- NCH, 2, number of channels (2..16).
- W, 1, bus width in bits (1..64).
- TURNAROUND, 1, idle cycles forced between owners (0..3).
- CNT_W, 8, width of the contention counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NCH  per-channel bus request
- to_pad  input  NCH*W  per-channel drive data; channel k occupies bits [k*W +: W]
- ie  input  NCH  per-channel input enable
- ext_in  input  W  value driven by the external agent
- ext_en  input  1  external agent drive enable
- clr_err  input  1  synchronous clear of contention and cnt
- gnt  output  NCH  one-hot grant, or all zero
- bus_out  output  W  driven bus value: to_pad of the owner, else 0
- bus_en  output  1  this block drives the bus
- from_pad  output  NCH*W  registered per-channel received value
- contention  output  1  sticky flag
- cnt  output  CNT_W  saturating contention-cycle count

Behaviour:
- Reset (asynchronous, rst_n=0):
  - gnt=0, bus_en=0, from_pad=0, contention=0, cnt=0, state=IDLE.
  - Round-robin pointer = NCH-1, so channel 0 wins first.
  - Reset asserted mid-ownership drops the bus in the same instant.
- States: IDLE, OWN, TURN. The FSM, gnt, turnaround counter and pointer are all registers.
- Arbitration (applies in IDLE, and in the last TURN cycle):
  - If any req is high, pick the first requester strictly after the pointer, wrapping modulo NCH.
  - Next cycle: gnt[k]=1, state=OWN, pointer=k.
  - Grant latency is 1 cycle from req.
- OWN:
  - bus_en=1 and bus_out=to_pad[k]; combinational from the registered gnt.
  - Ownership holds while req[k]=1. Other requests never pre-empt the owner.
  - When req[k]=0 is sampled: gnt=0 next cycle.
  - If TURNAROUND>0: state goes to TURN for TURNAROUND cycles, with bus_en=0 and no grant.
  - If TURNAROUND=0: arbitration happens in that same cycle, so a different channel owns next cycle with no gap. If only k re-requests, k is re-granted.
- TURN: counter counts down. In the last TURN cycle the block arbitrates; if there are no requests it goes to IDLE.
- Requests arriving during TURN are held by req level only; nothing is latched.
- Resolved bus: bus_val = (bus_en ? bus_out : 0) | (ext_en ? ext_in : 0).
- from_pad[k]: registered as ie[k] ? bus_val : 0, giving 1-cycle latency.
- Contention:
  - Any cycle with bus_en && ext_en sets contention (sticky) and increments cnt.
  - cnt saturates at all-ones and never wraps.
  - clr_err clears both; if clr_err coincides with a contention cycle, the clear wins.
- Invariant: popcount(gnt)<=1 always, and bus_en == |gnt.

Decomposition:
- Package tri_bus_pkg:
  - state_e enum (IDLE, OWN, TURN).
  - Constant TA_W = 2 for the turnaround counter.
  - A saturating-increment function.
- Sub-module rr_arbiter: parameter NCH; inputs req and ptr; outputs a one-hot winner and a valid bit. The arbiter is purely combinational; the pointer register stays in tri_bus_arbiter.

Test Plan:
- Reset, NCH=2, W=1, TURNAROUND=1: req=2'b11 at cycle 0 → gnt=01 at cycle 1.
  - Drop req[0] at cycle 3 → gnt=00 at cycle 4 (TURN), then gnt=10 at cycle 5.
- NCH=4, W=8, all req held, each owner drops after 2 cycles → grant order 0,1,2,3,0. Each owner sees exactly 1 bus_en=0 cycle between owners.
- TURNAROUND=0, req=11, owner 0 drops req → gnt goes 01→10 on consecutive cycles and bus_en stays 1.
- Owner 1 driving to_pad=8'hA5, ie[2]=1, ie[0]=0 → from_pad[2]=A5 and from_pad[0]=00, one cycle later.
- ext_en=1 with ext_in=8'h0F for 3 cycles while bus_en=1, owner driving 8'hF0:
  - Resolved bus value is FF, so from_pad of an enabled channel = FF.
  - contention=1 and cnt=3.
  - clr_err → both 0 next cycle.
  - With CNT_W=2, 5 contention cycles → cnt=3 (saturated).
- rst_n pulsed low mid-OWN (asynchronous, between clock edges) → gnt=0 and bus_en=0 immediately. After release, a req of 2'b10 is granted to channel 1 within 1 cycle.
